toggle_handshake_tx: RTL and testbench

Source-side transmitter for a two-phase (toggle) request/acknowledge handshake that carries a WIDTH-bit word from the clkA domain into an unrelated clock domain. It accepts words on a valid/ready interface and holds each word on a stable bus. It then toggles a request level, which the destination synchronizes with the standard 2-flop synchronizer. The destination returns an acknowledge toggle, which this block synchronizes internally before accepting the next word. It also reports completion and acknowledge timeouts.

---
 rtl/toggle_handshake_tx.sv | 79 +++++++
 tb/tb_toggle_handshake_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/toggle_handshake_tx.sv
// toggle_handshake_tx: source side of a two-phase req/ack handshake carrying a WIDTH-bit word out of clkA
//
// Ports:
//   clkA            source-domain clock (the only clock)
//   rstA_n          asynchronous active-low reset
//   DataIn_clkA     word offered on the valid/ready interface
//   ValidIn_clkA    DataIn_clkA is valid
//   ReadyOut_clkA   a word can be accepted this cycle
//   DataOut_clkA    registered word held stable for the destination
//   ReqToggle_clkA  request level, flips once per word
//   AckToggle_clkB  acknowledge level from the destination (asynchronous)
//   Done_clkA       one-cycle pulse when a transfer completes
//   Timeout_clkA    one-cycle pulse when the acknowledge is overdue
module toggle_handshake_tx #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic             clkA,
   input  logic             rstA_n,
   input  logic [WIDTH-1:0] DataIn_clkA,
   input  logic             ValidIn_clkA,
   output logic             ReadyOut_clkA,
   output logic [WIDTH-1:0] DataOut_clkA,
   output logic             ReqToggle_clkA,
   input  logic             AckToggle_clkB,
   output logic             Done_clkA,
   output logic             Timeout_clkA
);
   typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK} state_t;
   // Keep at least one counter bit so TIMEOUT=0 (disabled) still elaborates.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   state_t        state;
   logic          ackS0, ackS1;
   logic [CW-1:0] toCnt;
   logic          ackMatch, toHit;
   // Levels equal means no request is outstanding; a spurious ack flip also lands here as a mismatch.
   assign ackMatch      = ackS1 == ReqToggle_clkA;
   assign ReadyOut_clkA = (state == IDLE) && ackMatch;
   // Fires on the edge that completes the TIMEOUT-th unmatched WAIT_ACK cycle; saturation makes it one-shot.
   assign toHit         = (TIMEOUT != 0) && (toCnt == CW'(TIMEOUT - 1));
   always_ff @(posedge clkA or negedge rstA_n) begin
      if (!rstA_n) begin
         state          <= IDLE;
         ackS0          <= 1'b0;
         ackS1          <= 1'b0;
         toCnt          <= '0;
         DataOut_clkA   <= '0;
         ReqToggle_clkA <= 1'b0;
         Done_clkA      <= 1'b0;
         Timeout_clkA   <= 1'b0;
      end else begin
         ackS0        <= AckToggle_clkB;
         ackS1        <= ackS0;
         Done_clkA    <= 1'b0;
         Timeout_clkA <= 1'b0;
         case (state)
            IDLE: if (ValidIn_clkA && ReadyOut_clkA) begin
               DataOut_clkA <= DataIn_clkA;
               state        <= SETUP;
            end
            // One cycle of settled data before the request level moves.
            SETUP: begin
               ReqToggle_clkA <= ~ReqToggle_clkA;
               toCnt          <= '0;
               state          <= WAIT_ACK;
            end
            // The transfer is never aborted on timeout; a late ack still completes it.
            WAIT_ACK: if (ackMatch) begin
               state     <= IDLE;
               Done_clkA <= 1'b1;
            end else begin
               if (toCnt != CW'(TIMEOUT)) toCnt <= toCnt + CW'(1);
               Timeout_clkA <= toHit;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_toggle_handshake_tx.sv
// tb_toggle_handshake_tx: directed vectors for toggle_handshake_tx with TIMEOUT=16
module tb_toggle_handshake_tx;
   logic       clkA = 1'b0;
   logic       rstA_n = 1'b0;
   logic [7:0] dataIn = 8'h00;
   logic       validIn = 1'b0;
   logic       ready;
   logic [7:0] dataOut;
   logic       req;
   logic       ack = 1'b0;
   logic       done;
   logic       timeout;
   int         vectors = 0;
   int         miscompares = 0;

   toggle_handshake_tx #(.WIDTH(8), .TIMEOUT(16)) dut (
      .clkA(clkA), .rstA_n(rstA_n),
      .DataIn_clkA(dataIn), .ValidIn_clkA(validIn), .ReadyOut_clkA(ready),
      .DataOut_clkA(dataOut), .ReqToggle_clkA(req), .AckToggle_clkB(ack),
      .Done_clkA(done), .Timeout_clkA(timeout)
   );

   always #5 clkA = ~clkA;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clkA);
      #1;
   endtask

   task automatic doReset();
      rstA_n = 1'b0;
      #1;
      step();
      #2 rstA_n = 1'b1;
      step();
   endtask

   initial begin
      int pulses;
      // reset state
      #2;
      check("rst_req", req, 0);
      check("rst_dout", dataOut, 0);
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_to", timeout, 0);
      step();
      #2 rstA_n = 1'b1;
      repeat (3) step();
      check("idle_ready", ready, 1);
      check("idle_req", req, 0);
      check("idle_done", done, 0);

      // single word
      dataIn = 8'hA5; validIn = 1'b1;
      step();
      validIn = 1'b0;
      check("s_dout", dataOut, 8'hA5);
      check("s_ready_e0", ready, 0);
      check("s_req_e0", req, 0);
      step();
      check("s_req_e1", req, 1);
      repeat (3) step();
      ack = 1'b1;
      step();
      check("s_done_ea", done, 0);
      step();
      check("s_done_ea1", done, 0);
      check("s_ready_ea1", ready, 0);
      step();
      check("s_done_ea2", done, 1);
      check("s_ready_ea2", ready, 1);
      step();
      check("s_done_off", done, 0);
      check("s_to", timeout, 0);

      // back-to-back from a fresh reset
      ack = 1'b0;
      doReset();
      validIn = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         dataIn = 8'(i);
         step();
         check("b_dout_acc", dataOut, i);
         check("b_done_off", done, 0);
         dataIn = 8'hFF;
         step();
         check("b_req", req, i % 2);
         repeat (2) step();
         ack = req;
         repeat (2) step();
         check("b_dout_hold", dataOut, i);
         check("b_done_early", done, 0);
         step();
         check("b_done", done, 1);
         check("b_ready", ready, 1);
      end
      validIn = 1'b0;

      // timeout: req=1, ack=1 here
      dataIn = 8'h5C; validIn = 1'b1;
      step();
      validIn = 1'b0;
      step();
      check("t_req", req, 0);
      pulses = 0;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (timeout) pulses++;
         if (k == 15) check("t_to_15", timeout, 0);
         if (k == 16) check("t_to_16", timeout, 1);
         if (k == 17) check("t_to_17", timeout, 0);
      end
      ack = 1'b0;
      repeat (2) step();
      if (timeout) pulses++;
      check("t_done_early", done, 0);
      step();
      if (timeout) pulses++;
      check("t_done", done, 1);
      check("t_ready", ready, 1);
      check("t_pulses", pulses, 1);
      check("t_dout", dataOut, 8'h5C);

      // reset in WAIT_ACK with ack high
      dataIn = 8'h33; validIn = 1'b1;
      step();
      validIn = 1'b0;
      step();
      check("r_req1", req, 1);
      ack = 1'b1;
      step();
      rstA_n = 1'b0;
      #1;
      check("r_req0", req, 0);
      check("r_dout0", dataOut, 0);
      #1 rstA_n = 1'b1;
      repeat (2) step();
      check("r_ready_lo", ready, 0);
      dataIn = 8'h44; validIn = 1'b1;
      repeat (2) step();
      check("r_ignored", dataOut, 0);
      check("r_req_hold", req, 0);
      validIn = 1'b0; ack = 1'b0;
      step();
      check("r_ready_1", ready, 0);
      step();
      check("r_ready_2", ready, 1);

      // spurious ack in IDLE
      ack = 1'b1;
      step();
      check("p_ready_1", ready, 1);
      step();
      check("p_ready_2", ready, 0);
      dataIn = 8'h77; validIn = 1'b1;
      pulses = 0;
      repeat (3) begin
         step();
         if (done) pulses++;
      end
      check("p_no_done", pulses, 0);
      check("p_dout", dataOut, 0);
      check("p_req", req, 0);
      validIn = 1'b0; ack = 1'b0;
      step();
      check("p_back_1", ready, 0);
      step();
      check("p_back_2", ready, 1);
      check("p_done", done, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
